// File: rtl/lcd_write_sequencer_pkg.sv
// rtl/lcd_write_sequencer_pkg.sv - shared types, tables and timing constants for the LCD write sequencer
package lcd_write_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_PWR,
        ST_INIT_NIB,
        ST_INIT_WAIT,
        ST_IDLE,
        ST_UPPER,
        ST_LOWER,
        ST_WAIT
    } state_t;

    localparam int CNT_W = 22;

    // lcd_flags bit positions
    localparam int FLAG_RS = 1;
    localparam int FLAG_E  = 0;

    localparam logic [3:0] INIT_NIBS  [4] = '{4'h3, 4'h3, 4'h3, 4'h2};
    localparam logic [7:0] INIT_BYTES [4] = '{8'h28, 8'h06, 8'h0C, 8'h01};

    localparam int unsigned DEF_T_POWERUP  = 753664;
    localparam int unsigned DEF_T_INIT_GAP = 212992;
    localparam int unsigned DEF_T_BYTE     = 4096;
    localparam int unsigned DEF_T_LONG     = 98304;

    // Slot-relative cycle marks for E pulses and nibble switch-over
    localparam logic [CNT_W-1:0] E1_START = CNT_W'(16);
    localparam logic [CNT_W-1:0] E1_END   = CNT_W'(31);
    localparam logic [CNT_W-1:0] LO_START = CNT_W'(96);
    localparam logic [CNT_W-1:0] E2_START = CNT_W'(112);
    localparam logic [CNT_W-1:0] E2_END   = CNT_W'(127);

    function automatic logic [7:0] hex_ascii(input logic [3:0] d);
        return (d <= 4'd9) ? (8'h30 + {4'h0, d}) : (8'h37 + {4'h0, d});
    endfunction

    // Clear and home commands need the long execution slot
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] b);
        return !rs && ((b == 8'h01) || (b == 8'h02) || (b == 8'h03));
    endfunction

endpackage

// File: rtl/lcd_write_sequencer_if.sv
// rtl/lcd_write_sequencer_if.sv - requester A/B handshake bundle for the LCD write sequencer
// master: requester side (drives valid/rs/hex/byte), slave: sequencer side (drives ready).
interface lcd_write_sequencer_if;
    logic       a_valid;
    logic       a_rs;
    logic       a_hex;
    logic [7:0] a_byte;
    logic       a_ready;
    logic       b_valid;
    logic       b_rs;
    logic       b_hex;
    logic [7:0] b_byte;
    logic       b_ready;

    modport master (
        output a_valid, a_rs, a_hex, a_byte, b_valid, b_rs, b_hex, b_byte,
        input  a_ready, b_ready
    );

    modport slave (
        input  a_valid, a_rs, a_hex, a_byte, b_valid, b_rs, b_hex, b_byte,
        output a_ready, b_ready
    );
endinterface

// File: rtl/lcd_write_sequencer_nibble_tx.sv
// rtl/lcd_write_sequencer_nibble_tx.sv - slot counter and E/data waveform generator (lcd_nibble_tx)
// Ports: i_clk/i_rst clock and sync reset; i_clr restarts the slot counter;
// i_active/i_nib_only select waveform; i_last_cnt final slot cycle; i_hi/i_lo nibbles;
// o_cnt slot counter, o_last final cycle flag, o_e enable strobe, o_data DB7..DB4.
module lcd_nibble_tx
    import lcd_write_sequencer_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_active,
    input  logic             i_nib_only,
    input  logic [CNT_W-1:0] i_last_cnt,
    input  logic [3:0]       i_hi,
    input  logic [3:0]       i_lo,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_last,
    output logic             o_e,
    output logic [3:0]       o_data
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_e1;
    logic             w_e2;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_last = (r_cnt == i_last_cnt);
    assign w_e1   = (r_cnt >= E1_START) && (r_cnt <= E1_END);
    assign w_e2   = (r_cnt >= E2_START) && (r_cnt <= E2_END);
    assign o_e    = i_active && (w_e1 || (!i_nib_only && w_e2));

    // Data switches only at cycles 0, 96 and the final cycle, all outside E pulses
    always_comb begin
        o_data = 4'h0;
        if (i_active) begin
            if (i_nib_only) begin
                o_data = i_hi;
            end else if (o_last) begin
                o_data = 4'h0;
            end else if (r_cnt < LO_START) begin
                o_data = i_hi;
            end else begin
                o_data = i_lo;
            end
        end
    end

endmodule

// File: rtl/lcd_write_sequencer.sv
// rtl/lcd_write_sequencer.sv - HD44780 4-bit write sequencer with power-up init and A/B round-robin arbiter
// Ports: qzt_clk clock; rst sync active-high reset; req requester handshake (slave);
// init_done init complete; busy not IDLE; lcd_flags {RS,E}; lcd_data DB7..DB4.
// Optional macro LCD_SEQ_HEX_EN: converts hex=1 requests to ASCII digits on capture.
module lcd_write_sequencer
    import lcd_write_sequencer_pkg::*;
#(
    parameter int unsigned T_POWERUP  = DEF_T_POWERUP,
    parameter int unsigned T_INIT_GAP = DEF_T_INIT_GAP,
    parameter int unsigned T_BYTE     = DEF_T_BYTE,
    parameter int unsigned T_LONG     = DEF_T_LONG
) (
    input  logic                 qzt_clk,
    input  logic                 rst,
    lcd_write_sequencer_if.slave req,
    output logic                 init_done,
    output logic                 busy,
    output logic [1:0]           lcd_flags,
    output logic [3:0]           lcd_data
);

    localparam logic [CNT_W-1:0] L_PWR_END  = CNT_W'(T_POWERUP - 1);
    localparam logic [CNT_W-1:0] L_GAP_END  = CNT_W'(T_INIT_GAP - 1);
    localparam logic [CNT_W-1:0] L_BYTE_END = CNT_W'(T_BYTE - 1);
    localparam logic [CNT_W-1:0] L_LONG_END = CNT_W'(T_LONG - 1);

    state_t           r_state;
    state_t           w_next;
    logic [1:0]       r_idx;
    logic             r_rs;
    logic [7:0]       r_byte;
    logic             r_init_done;
    logic             r_last_b;

    logic [CNT_W-1:0] w_cnt;
    logic [CNT_W-1:0] w_last_cnt;
    logic             w_last;
    logic             w_e;
    logic [3:0]       w_data;
    logic             w_clr;
    logic             w_in_slot;
    logic             w_can_accept;
    logic             w_grant_a;
    logic             w_grant_b;
    logic [7:0]       w_a_byte;
    logic [7:0]       w_b_byte;
    logic [3:0]       w_hi;

`ifdef LCD_SEQ_HEX_EN
    assign w_a_byte = req.a_hex ? hex_ascii(req.a_byte[3:0]) : req.a_byte;
    assign w_b_byte = req.b_hex ? hex_ascii(req.b_byte[3:0]) : req.b_byte;
`else
    assign w_a_byte = req.a_byte;
    assign w_b_byte = req.b_byte;
`endif

    // Round robin: a lone requester wins, on contention the one not served last wins
    assign w_can_accept = (r_state == ST_IDLE) && r_init_done;
    assign w_grant_a    = w_can_accept && req.a_valid && (!req.b_valid || r_last_b);
    assign w_grant_b    = w_can_accept && req.b_valid && !w_grant_a;

    assign w_in_slot  = (r_state == ST_UPPER) || (r_state == ST_LOWER) || (r_state == ST_WAIT);
    assign w_last_cnt = is_long_cmd(r_rs, r_byte) ? L_LONG_END : L_BYTE_END;
    assign w_hi       = (r_state == ST_INIT_NIB) ? INIT_NIBS[r_idx] : r_byte[7:4];
    // The counter runs continuously through UPPER->LOWER->WAIT so it stays slot-relative
    assign w_clr      = (w_next != r_state) && (w_next != ST_LOWER) && (w_next != ST_WAIT);

    lcd_nibble_tx u_tx (
        .i_clk      (qzt_clk),
        .i_rst      (rst),
        .i_clr      (w_clr),
        .i_active   (w_in_slot || (r_state == ST_INIT_NIB)),
        .i_nib_only (r_state == ST_INIT_NIB),
        .i_last_cnt (w_last_cnt),
        .i_hi       (w_hi),
        .i_lo       (r_byte[3:0]),
        .o_cnt      (w_cnt),
        .o_last     (w_last),
        .o_e        (w_e),
        .o_data     (w_data)
    );

    always_ff @(posedge qzt_clk) begin
        if (rst) begin
            r_state <= ST_PWR;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_PWR:       if (w_cnt == L_PWR_END) w_next = ST_INIT_NIB;
            ST_INIT_NIB:  if (w_cnt == E1_END) w_next = ST_INIT_WAIT;
            ST_INIT_WAIT: if (w_cnt == L_GAP_END) w_next = (r_idx == 2'd3) ? ST_UPPER : ST_INIT_NIB;
            ST_IDLE:      if (w_grant_a || w_grant_b) w_next = ST_UPPER;
            ST_UPPER:     if (w_cnt == LO_START - 1'b1) w_next = ST_LOWER;
            ST_LOWER:     if (w_cnt == E2_END) w_next = ST_WAIT;
            ST_WAIT:      if (w_last) w_next = (r_init_done || r_idx == 2'd3) ? ST_IDLE : ST_UPPER;
            default:      w_next = ST_PWR;
        endcase
    end

    always_comb begin
        busy                = (r_state != ST_IDLE);
        init_done           = r_init_done;
        lcd_flags           = 2'b00;
        lcd_flags[FLAG_E]   = w_e;
        lcd_flags[FLAG_RS]  = w_in_slot && r_rs;
        lcd_data            = w_data;
        req.a_ready         = w_grant_a;
        req.b_ready         = w_grant_b;
    end

    // r_idx walks the nibble table, then is reused to walk the init byte table
    always_ff @(posedge qzt_clk) begin
        if (rst) begin
            r_idx       <= 2'd0;
            r_rs        <= 1'b0;
            r_byte      <= 8'h00;
            r_init_done <= 1'b0;
            r_last_b    <= 1'b1;
        end else if (r_state == ST_INIT_WAIT && w_cnt == L_GAP_END) begin
            r_idx <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
                r_byte <= INIT_BYTES[0];
                r_rs   <= 1'b0;
            end
        end else if (r_state == ST_WAIT && w_last && !r_init_done) begin
            if (r_idx == 2'd3) begin
                r_init_done <= 1'b1;
            end else begin
                r_idx  <= r_idx + 2'd1;
                r_byte <= INIT_BYTES[r_idx + 2'd1];
            end
        end else if (w_grant_a) begin
            r_rs     <= req.a_rs;
            r_byte   <= w_a_byte;
            r_last_b <= 1'b0;
        end else if (w_grant_b) begin
            r_rs     <= req.b_rs;
            r_byte   <= w_b_byte;
            r_last_b <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// tb/tb_lcd_write_sequencer.sv - self-checking bench for lcd_write_sequencer
module tb_lcd_write_sequencer;

    localparam int T_POWERUP  = 200;
    localparam int T_INIT_GAP = 50;
    localparam int T_BYTE     = 256;
    localparam int T_LONG     = 400;

    logic       clk = 1'b0;
    logic       rst;
    logic       init_done;
    logic       busy;
    logic [1:0] lcd_flags;
    logic [3:0] lcd_data;
    int         cyc = 0;
    int         base;
    int         n_checks = 0;
    int         n_err = 0;

    lcd_write_sequencer_if u_if ();

    lcd_write_sequencer #(
        .T_POWERUP  (T_POWERUP),
        .T_INIT_GAP (T_INIT_GAP),
        .T_BYTE     (T_BYTE),
        .T_LONG     (T_LONG)
    ) u_dut (
        .qzt_clk   (clk),
        .rst       (rst),
        .req       (u_if),
        .init_done (init_done),
        .busy      (busy),
        .lcd_flags (lcd_flags),
        .lcd_data  (lcd_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1);
    end

    typedef struct {
        int         k;
        logic       e;
        logic       rs;
        logic [3:0] data;
        logic       bsy;
        logic       done;
        logic       ardy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int k, logic e, logic rs, logic [3:0] d, logic b, logic dn, logic r);
        vec_t v;
        v.k = k; v.e = e; v.rs = rs; v.data = d; v.bsy = b; v.done = dn; v.ardy = r;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_abs(input int c);
        @(negedge clk);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_ready(input int bound, output bit got_b, output int t);
        bit found;
        found = 0;
        got_b = 0;
        t = -1;
        #1;
        for (int i = 0; i < bound && !found; i++) begin
            if (u_if.a_ready || u_if.b_ready) begin
                found = 1;
                got_b = u_if.b_ready;
                t = cyc;
                chk("single_ready", 32'(u_if.a_ready & u_if.b_ready), 32'd0);
            end else begin
                @(negedge clk);
                #1;
            end
        end
        if (!found) begin
            n_checks++;
            n_err++;
            $display("FAIL ready_timeout: no ready within %0d cycles, expected a grant", bound);
        end
    endtask

    initial begin
        bit         gb;
        int         t, t1, t2, prev;
        logic [3:0] exp_hi, exp_lo;

        rst = 1'b1;
        u_if.a_valid = 1'b1; u_if.a_rs = 1'b1; u_if.a_hex = 1'b0; u_if.a_byte = 8'h41;
        u_if.b_valid = 1'b0; u_if.b_rs = 1'b0; u_if.b_hex = 1'b0; u_if.b_byte = 8'h00;

        // Init sequence with A already pending: stalled until init_done, then 0x41 slot
        tbl.push_back(mk(0,    0, 0, 4'h0, 1, 0, 0));
        tbl.push_back(mk(199,  0, 0, 4'h0, 1, 0, 0));
        tbl.push_back(mk(200,  0, 0, 4'h3, 1, 0, 0));
        tbl.push_back(mk(215,  0, 0, 4'h3, 1, 0, 0));
        tbl.push_back(mk(216,  1, 0, 4'h3, 1, 0, 0));
        tbl.push_back(mk(231,  1, 0, 4'h3, 1, 0, 0));
        tbl.push_back(mk(232,  0, 0, 4'h0, 1, 0, 0));
        tbl.push_back(mk(298,  1, 0, 4'h3, 1, 0, 0));
        tbl.push_back(mk(380,  1, 0, 4'h3, 1, 0, 0));
        tbl.push_back(mk(462,  1, 0, 4'h2, 1, 0, 0));
        tbl.push_back(mk(528,  0, 0, 4'h2, 1, 0, 0));
        tbl.push_back(mk(544,  1, 0, 4'h2, 1, 0, 0));
        tbl.push_back(mk(624,  0, 0, 4'h8, 1, 0, 0));
        tbl.push_back(mk(640,  1, 0, 4'h8, 1, 0, 0));
        tbl.push_back(mk(656,  0, 0, 4'h8, 1, 0, 0));
        tbl.push_back(mk(783,  0, 0, 4'h0, 1, 0, 0));
        tbl.push_back(mk(800,  1, 0, 4'h0, 1, 0, 0));
        tbl.push_back(mk(896,  1, 0, 4'h6, 1, 0, 0));
        tbl.push_back(mk(1056, 1, 0, 4'h0, 1, 0, 0));
        tbl.push_back(mk(1152, 1, 0, 4'hC, 1, 0, 0));
        tbl.push_back(mk(1312, 1, 0, 4'h0, 1, 0, 0));
        tbl.push_back(mk(1408, 1, 0, 4'h1, 1, 0, 0));
        tbl.push_back(mk(1551, 0, 0, 4'h1, 1, 0, 0));
        tbl.push_back(mk(1695, 0, 0, 4'h0, 1, 0, 0));
        tbl.push_back(mk(1696, 0, 0, 4'h0, 0, 1, 1));
        tbl.push_back(mk(1697, 0, 1, 4'h4, 1, 1, 0));
        tbl.push_back(mk(1713, 1, 1, 4'h4, 1, 1, 0));
        tbl.push_back(mk(1728, 1, 1, 4'h4, 1, 1, 0));
        tbl.push_back(mk(1729, 0, 1, 4'h4, 1, 1, 0));
        tbl.push_back(mk(1793, 0, 1, 4'h1, 1, 1, 0));
        tbl.push_back(mk(1809, 1, 1, 4'h1, 1, 1, 0));
        tbl.push_back(mk(1824, 1, 1, 4'h1, 1, 1, 0));
        tbl.push_back(mk(1825, 0, 1, 4'h1, 1, 1, 0));
        tbl.push_back(mk(1952, 0, 1, 4'h0, 1, 1, 0));
        tbl.push_back(mk(1953, 0, 0, 4'h0, 0, 1, 0));

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        base = cyc;

        foreach (tbl[i]) begin
            wait_abs(base + tbl[i].k);
            chk($sformatf("e@%0d", tbl[i].k),    32'(lcd_flags[0]), 32'(tbl[i].e));
            chk($sformatf("rs@%0d", tbl[i].k),   32'(lcd_flags[1]), 32'(tbl[i].rs));
            chk($sformatf("data@%0d", tbl[i].k), 32'(lcd_data),     32'(tbl[i].data));
            chk($sformatf("busy@%0d", tbl[i].k), 32'(busy),         32'(tbl[i].bsy));
            chk($sformatf("done@%0d", tbl[i].k), 32'(init_done),    32'(tbl[i].done));
            chk($sformatf("ardy@%0d", tbl[i].k), 32'(u_if.a_ready), 32'(tbl[i].ardy));
            if (tbl[i].k == 1697) u_if.a_valid = 1'b0;
        end

        // Hex request from B
`ifdef LCD_SEQ_HEX_EN
        exp_hi = 4'h4; exp_lo = 4'h3;
`else
        exp_hi = 4'h0; exp_lo = 4'hC;
`endif
        u_if.b_valid = 1'b1; u_if.b_rs = 1'b1; u_if.b_hex = 1'b1; u_if.b_byte = 8'h0C;
        wait_ready(400, gb, t);
        chk("hex_grant_b", 32'(gb), 32'd1);
        @(negedge clk);
        u_if.b_valid = 1'b0; u_if.b_hex = 1'b0;
        wait_abs(t + 17);
        chk("hex_hi_e", 32'(lcd_flags[0]), 32'd1);
        chk("hex_hi", 32'(lcd_data), 32'(exp_hi));
        chk("hex_rs", 32'(lcd_flags[1]), 32'd1);
        wait_abs(t + 113);
        chk("hex_lo_e", 32'(lcd_flags[0]), 32'd1);
        chk("hex_lo", 32'(lcd_data), 32'(exp_lo));
        wait_abs(t + 1 + T_BYTE);
        chk("hex_idle", 32'(busy), 32'd0);

        // Contention: last grant was B, so A,B,A,B with a 1-cycle IDLE between slots
        u_if.a_valid = 1'b1; u_if.a_rs = 1'b1; u_if.a_byte = 8'h41;
        u_if.b_valid = 1'b1; u_if.b_rs = 1'b1; u_if.b_byte = 8'h42;
        prev = -1;
        for (int i = 0; i < 4; i++) begin
            wait_ready(600, gb, t);
            chk($sformatf("rr_grant%0d", i), 32'(gb), 32'(i % 2));
            if (i > 0) chk($sformatf("rr_gap%0d", i), 32'(t - prev), 32'(T_BYTE + 1));
            prev = t;
            @(negedge clk);
        end
        u_if.a_valid = 1'b0; u_if.b_valid = 1'b0;
        wait_abs(prev + 1 + T_BYTE);

        // Clear display takes the long slot
        u_if.a_valid = 1'b1; u_if.a_rs = 1'b0; u_if.a_byte = 8'h01;
        wait_ready(600, gb, t1);
        chk("long_grant_a", 32'(gb), 32'd0);
        @(negedge clk);
        u_if.a_byte = 8'h80;
        wait_ready(1000, gb, t2);
        chk("long_spacing", 32'(t2 - t1), 32'(T_LONG + 1));
        @(negedge clk);
        u_if.a_valid = 1'b0;
        wait_abs(t2 + 1 + T_BYTE);

        // Reset in the middle of the first E pulse
        u_if.a_valid = 1'b1; u_if.a_rs = 1'b1; u_if.a_byte = 8'h41;
        wait_ready(600, gb, t);
        @(negedge clk);
        u_if.a_valid = 1'b0;
        wait_abs(t + 21);
        chk("rst_pre_e", 32'(lcd_flags[0]), 32'd1);
        rst = 1'b1;
        u_if.a_valid = 1'b1; u_if.b_valid = 1'b1;
        wait_abs(t + 22);
        chk("rst_flags", 32'(lcd_flags), 32'd0);
        chk("rst_data", 32'(lcd_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_done", 32'(init_done), 32'd0);
        chk("rst_ready", 32'({u_if.a_ready, u_if.b_ready}), 32'd0);
        rst = 1'b0;
        base = t + 22;
        wait_abs(base + 216);
        chk("rst_nib0_e", 32'(lcd_flags[0]), 32'd1);
        chk("rst_nib0_d", 32'(lcd_data), 32'd3);
        wait_abs(base + 1695);
        chk("rst_stall_done", 32'(init_done), 32'd0);
        chk("rst_stall_rdy", 32'({u_if.a_ready, u_if.b_ready}), 32'd0);
        wait_ready(100, gb, t);
        chk("rst_first_a", 32'(gb), 32'd0);
        chk("rst_first_t", 32'(t - base), 32'd1696);
        @(negedge clk);
        u_if.a_valid = 1'b0; u_if.b_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/lcd_write_sequencer.md
LCD_WRITE_SEQUENCER -- requirements
Module: lcd_write_sequencer

Interface
REQ-001 Parameter T_POWERUP, default 753664: cycles from reset release to first init nibble.
REQ-002 Parameter T_INIT_GAP, default 212992: wait after each init nibble-only write.
REQ-003 Parameter T_BYTE, default 4096: full slot length of one byte write.
REQ-004 Parameter T_LONG, default 98304: slot length for clear/home commands.
REQ-005 qzt_clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 a_valid, b_valid  in  1 each  requester A/B has a byte pending.
REQ-008 a_rs, b_rs  in  1 each  0 = command, 1 = data.
REQ-009 a_hex, b_hex  in  1 each  byte[3:0] is a hex digit to print (see REQ-031).
REQ-010 a_byte, b_byte  in  8 each  byte to write.
REQ-011 a_ready, b_ready  out  1 each  accept strobe; transfer occurs on valid & ready in the same cycle.
REQ-012 init_done  out  1  high once the init sequence completes.
REQ-013 busy  out  1  high whenever the state is not IDLE.
REQ-014 lcd_flags  out  2  [1] = RS, [0] = E.
REQ-015 lcd_data  out  4  LCD DB7..DB4.

Function
REQ-016 States: PWR, INIT_NIB, INIT_WAIT, IDLE, UPPER, LOWER, WAIT; a slot counter of at least 22 bits times every state.
REQ-017 PWR: wait T_POWERUP cycles, then go to INIT_NIB.
REQ-018 INIT_NIB sends nibbles 0x3, 0x3, 0x3, 0x2 with RS=0, each followed by T_INIT_GAP in INIT_WAIT.
REQ-019 After the nibbles, send command bytes 0x28, 0x06, 0x0C, 0x01 through UPPER/LOWER/WAIT, using the normal byte timing.
REQ-020 When the last init byte completes, init_done goes high and the state goes to IDLE.
REQ-021 Byte timing, relative to slot cycle 0:
- cycle 0: upper nibble on lcd_data; RS valid.
- cycles 16-31: E=1.
- cycle 96: lower nibble on lcd_data.
- cycles 112-127: E=1.
- cycle T_BYTE-1: lcd_data=0; slot ends.
REQ-022 RS is held for the whole slot; lcd_data and RS change only while E=0.
REQ-023 Nibble-only timing: data at cycle 0, E=1 for cycles 16-31, then INIT_WAIT.
REQ-024 The slot is T_LONG instead of T_BYTE when rs=0 and byte is 0x01, 0x02 or 0x03.
REQ-025 a_ready/b_ready are asserted only in IDLE with init_done=1, for at most one requester per cycle.
REQ-026 Arbitration is round-robin.
- One valid requester: it is granted.
- Both valid: the requester not granted last is granted.
- The last-grant pointer resets to B, so A wins the first contention.
REQ-027 On accept, {rs, hex, byte} is captured and the state goes to UPPER the next cycle; inputs may then change freely.
REQ-028 Back-to-back: IDLE lasts exactly 1 cycle between slots if valid is already pending.
REQ-029 Requests before init_done are stalled, not dropped; ready stays 0.

Reset
REQ-030 rst forces the following on the next edge, from any state including mid-slot:
- state PWR, counter 0, pointer B;
- lcd_flags=00, lcd_data=0000;
- a_ready=b_ready=0, init_done=0, busy=1.
The init sequence then restarts in full.

Configuration
REQ-031 Macro LCD_SEQ_HEX_EN controls hex printing.
- Defined: a byte captured with hex=1 is replaced by ASCII: 0x30+d for d<=9, 0x37+d for d>=10; byte[7:4] is ignored.
- Undefined: the hex inputs are ignored and the byte is sent unchanged.

Structure
REQ-032 A shared package holds the state enum, the flag bit indices (RS=1, E=0), the init nibble/byte tables and the default timing constants.
REQ-033 One sub-module, lcd_nibble_tx, generates the slot counter and the E/data timing of REQ-021/REQ-023; the parent holds the arbiter, init sequencing and FSM.

Verification
REQ-034 Reset release, no requests -> nibbles 3,3,3,2 at T_POWERUP + k*(T_INIT_GAP+32), then bytes 28, 06, 0C, 01; init_done rises after the 0x01 T_LONG slot.
REQ-035 A writes rs=1 0x41 -> upper 0x4 with E at slot cycles 16-31, lower 0x1 with E at cycles 112-127, RS=1 throughout; busy for 4096 cycles.
REQ-036 A and B valid continuously -> grants alternate A,B,A,B; each IDLE gap is 1 cycle.
REQ-037 With LCD_SEQ_HEX_EN, B sends hex=1 byte 0x0C -> nibbles 0x4, 0x3 ('C'); without the macro -> 0x0, 0xC.
REQ-038 rst asserted at slot cycle 20 (E high) -> next cycle E=0, data=0, state PWR; full init repeats.
REQ-039 Command 0x01 from A followed by A 0x80 -> second accept exactly T_LONG+1 cycles after the first.
